// File: rtl/gate_truth_table_sequencer.sv
// Stimulus/checker sequencer for a 2-input gate under test: walks rows 0..3, samples gate_out,
// and compares it to EXPECTED_TT. Optional macro STOP_ON_FAIL_EN ends the run at the first bad row.
module gate_truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED_TT   = 4'b1001
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic       i_gate_out,
    output logic       o_gate_a,
    output logic       o_gate_b,
    output logic [1:0] o_row,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_captured_tt,
    output logic [3:0] o_fail_mask
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DRIVE   = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [3:0] SETTLE_LD = SETTLE_CYCLES[3:0];

    logic [2:0] r_state;
    logic [1:0] r_row;
    logic       r_gate_a;
    logic       r_gate_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_captured_tt;
    logic [3:0] r_fail_mask;
    logic [3:0] r_settle_cnt;

    logic       w_row_fail;
    logic       w_stop;
    logic [1:0] w_row_inc;
    logic [3:0] w_cap_nxt;
    logic [3:0] w_fm_nxt;

    assign w_row_fail = i_gate_out ^ EXPECTED_TT[r_row];
    assign w_row_inc  = r_row + 2'd1;

`ifdef STOP_ON_FAIL_EN
    assign w_stop = w_row_fail;
`else
    assign w_stop = 1'b0;
`endif

    always_comb begin
        w_cap_nxt        = r_captured_tt;
        w_fm_nxt         = r_fail_mask;
        w_cap_nxt[r_row] = i_gate_out;
        w_fm_nxt[r_row]  = w_row_fail;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_row         <= 2'd0;
            r_gate_a      <= 1'b0;
            r_gate_b      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_captured_tt <= 4'd0;
            r_fail_mask   <= 4'd0;
            r_settle_cnt  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state       <= S_DRIVE;
                        r_row         <= 2'd0;
                        r_gate_a      <= 1'b0;
                        r_gate_b      <= 1'b0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_captured_tt <= 4'd0;
                        r_fail_mask   <= 4'd0;
                    end
                end
                S_DRIVE: begin
                    if (SETTLE_CYCLES != 0) begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= SETTLE_LD;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt <= 4'd1) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    r_captured_tt <= w_cap_nxt;
                    r_fail_mask   <= w_fm_nxt;
                    if (r_row == 2'd3 || w_stop) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_fm_nxt == 4'd0);
                    end else begin
                        // Next row's gate inputs launch on this edge so DRIVE sees them stable.
                        r_row    <= w_row_inc;
                        r_gate_a <= w_row_inc[1];
                        r_gate_b <= w_row_inc[0];
                        r_state  <= S_DRIVE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_gate_a      = r_gate_a;
    assign o_gate_b      = r_gate_b;
    assign o_row         = r_row;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_pass        = r_pass;
    assign o_captured_tt = r_captured_tt;
    assign o_fail_mask   = r_fail_mask;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Bench for gate_truth_table_sequencer: default instance plus a SETTLE_CYCLES=0 instance,
// each driving a modelled gate. Build with STOP_ON_FAIL_EN to exercise early termination.
module tb_gate_truth_table_sequencer;

    typedef struct {
        int         mode;
        logic [3:0] cap;
        logic [3:0] fm;
        logic       pass;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    int   mode = 0;
    int   cur = 0;

    logic       gout0, a0, b0, busy0, done0, pass0;
    logic [1:0] row0;
    logic [3:0] cap0, fm0;
    logic       gout1, a1, b1, busy1, done1, pass1;
    logic [1:0] row1;
    logic [3:0] cap1, fm1;

    logic       m_a, m_b, m_busy, m_done, m_pass;
    logic [1:0] m_row;
    logic [3:0] m_cap, m_fm;

    int   total = 0;
    int   bad = 0;
    vec_t sb_q[$];
    vec_t tbl[7];

    always #5 clk = ~clk;

    // 0 XNOR, 1 tied-0, 2 XOR, 3 NAND, 4 tied-1, 5 AND, 6 OR
    function automatic logic gate_fn(input int m, input logic a, input logic b);
        case (m)
            0:       return ~(a ^ b);
            1:       return 1'b0;
            2:       return a ^ b;
            3:       return ~(a & b);
            4:       return 1'b1;
            5:       return a & b;
            default: return a | b;
        endcase
    endfunction

    always_comb gout0 = gate_fn(mode, a0, b0);
    always_comb gout1 = gate_fn(mode, a1, b1);

    always_comb begin
        m_a = a0; m_b = b0; m_row = row0; m_busy = busy0;
        m_done = done0; m_pass = pass0; m_cap = cap0; m_fm = fm0;
        if (cur == 1) begin
            m_a = a1; m_b = b1; m_row = row1; m_busy = busy1;
            m_done = done1; m_pass = pass1; m_cap = cap1; m_fm = fm1;
        end
    end

    gate_truth_table_sequencer u_dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start0), .i_gate_out(gout0),
        .o_gate_a(a0), .o_gate_b(b0), .o_row(row0), .o_busy(busy0), .o_done(done0),
        .o_pass(pass0), .o_captured_tt(cap0), .o_fail_mask(fm0)
    );

    gate_truth_table_sequencer #(.SETTLE_CYCLES(0)) u_dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start1), .i_gate_out(gout1),
        .o_gate_a(a1), .o_gate_b(b1), .o_row(row1), .o_busy(busy1), .o_done(done1),
        .o_pass(pass1), .o_captured_tt(cap1), .o_fail_mask(fm1)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_dut0"}, int'({a0, b0, row0, busy0, done0, pass0, cap0, fm0}), 0);
        chk({name, "_dut1"}, int'({a1, b1, row1, busy1, done1, pass1, cap1, fm1}), 0);
    endtask

    // Accept edge is edge 0; checks per-cycle row/gate inputs, then pops the scoreboard at done.
    task automatic run_one(input int sel, input vec_t v, input int exp_edges);
        int   edges;
        int   per_row;
        vec_t e;
        per_row = exp_edges / 4;
        cur = sel;
        mode = v.mode;
        sb_q.push_back(v);
        @(negedge clk);
        if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        edges = 0;
        chk("clear_on_accept", int'({m_done, m_pass, m_cap, m_fm}), 0);
        while (!m_done && edges < 100) begin
            chk("row", int'(m_row), edges / per_row);
            chk("gate_ab", int'({m_a, m_b}), edges / per_row);
            chk("busy_run", int'(m_busy), 1);
            @(posedge clk); #1;
            edges++;
        end
        chk("done_seen", int'(m_done), 1);
        chk("done_edge", edges, exp_edges);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("captured_tt", int'(m_cap), int'(e.cap));
            chk("fail_mask", int'(m_fm), int'(e.fm));
            chk("pass", int'(m_pass), int'(e.pass));
            chk("busy_at_done", int'(m_busy), 0);
            chk("row_at_done", int'(m_row), 3);
        end
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (!m_done && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen_wait", int'(m_done), 1);
    endtask

    initial begin
        tbl[0] = '{mode: 0, cap: 4'b1001, fm: 4'b0000, pass: 1'b1};
        tbl[1] = '{mode: 1, cap: 4'b0000, fm: 4'b1001, pass: 1'b0};
        tbl[2] = '{mode: 2, cap: 4'b0110, fm: 4'b1111, pass: 1'b0};
        tbl[3] = '{mode: 3, cap: 4'b0111, fm: 4'b1110, pass: 1'b0};
        tbl[4] = '{mode: 4, cap: 4'b1111, fm: 4'b0110, pass: 1'b0};
        tbl[5] = '{mode: 5, cap: 4'b1000, fm: 4'b0001, pass: 1'b0};
        tbl[6] = '{mode: 6, cap: 4'b1110, fm: 4'b0111, pass: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("idle_after_reset");

`ifndef STOP_ON_FAIL_EN
        foreach (tbl[i]) run_one(0, tbl[i], 16);
        foreach (tbl[i]) run_one(1, tbl[i], 8);

        // Reset during SETTLE of row 2 (edge 9 after accept), then a clean run.
        cur = 0;
        mode = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("row_before_abort", int'(row0), 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_abort");
        @(negedge clk);
        rst_n = 1'b1;
        run_one(0, tbl[0], 16);

        // start held high through the run: ignored while busy, accepted on the first DONE cycle.
        cur = 0;
        mode = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        repeat (16) begin
            chk("held_no_restart", int'(done0), 0);
            @(posedge clk); #1;
        end
        chk("held_done", int'(done0), 1);
        chk("held_pass", int'(pass0), 1);
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("held_done_one_cycle", int'(done0), 0);
        chk("held_restart_busy", int'(busy0), 1);
        chk("held_restart_row", int'(row0), 0);
        wait_done(40);
        chk("held_second_pass", int'(pass0), 1);
        chk("held_second_cap", int'(cap0), 9);
`else
        // XOR instead of XNOR: row 0 mismatches and the run stops after one row.
        cur = 0;
        mode = 2;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) begin
            chk("stop_not_done_yet", int'(done0), 0);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("stop_done_edge4", int'(done0), 1);
        chk("stop_row", int'(row0), 0);
        chk("stop_fail_mask", int'(fm0), 1);
        chk("stop_captured", int'(cap0), 0);
        chk("stop_pass", int'(pass0), 0);
        chk("stop_busy", int'(busy0), 0);
        run_one(0, tbl[0], 16);
        run_one(1, tbl[0], 8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
